// File: rtl/word_serializer_if.sv
// Handshake bundle between a word producer, the serializer and the serial sink.
// The master modport belongs to the upstream/downstream side; the slave modport belongs to the serializer.
interface word_serializer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_last;
   logic             zr;
   logic             done;

   modport master (
      output in_data, in_valid, ser_ready,
      input  in_ready, ser_out, ser_valid, ser_last, zr, done
   );

   modport slave (
      input  in_data, in_valid, ser_ready,
      output in_ready, ser_out, ser_valid, ser_last, zr, done
   );
endinterface

// File: rtl/word_serializer.sv
// Parallel-in/serial-out transmitter: takes one WIDTH-bit word over valid/ready,
// sends it one bit per accepted beat and flags an all-zero word on zr.
module word_serializer #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic               clock,
   input  logic               reset_n,
   word_serializer_if.slave   bus
);
   localparam int              CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zr_q, zr_d;

   logic accept;
   logic beat;
   logic word_zero;

   assign accept    = (state_q == S_IDLE) && bus.in_valid;
   assign beat      = (state_q == S_SHIFT) && bus.ser_ready;
   assign word_zero = ~|bus.in_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         zr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         zr_q    <= zr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = (SKIP_ZERO && word_zero) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bus.ser_ready && (cnt_q == '0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shift register always moves toward the output end so ser_out is a fixed tap.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      zr_d    = zr_q;
      if (accept) begin
         shift_d = bus.in_data;
         cnt_d   = CNT_MAX;
         zr_d    = word_zero;
      end else if (beat) begin
         shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == S_IDLE) && reset_n;
      bus.ser_valid = (state_q == S_SHIFT);
      bus.ser_last  = (state_q == S_SHIFT) && (cnt_q == '0);
      bus.done      = (state_q == S_DONE);
      bus.ser_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
      bus.zr        = zr_q;
   end
endmodule
